// File: rtl/maze_rotator_pipe.sv
`timescale 1ns/1ps
// maze_rotator_pipe
//   Maps a screen-space maze cell (in_x, in_y) to a linear cell index in maze
//   storage. The mapping depends on the current orientation: a quarter-turn
//   direction plus an optional horizontal mirror. Rotate, mirror and load
//   commands update that orientation.
//   The datapath is a two-stage valid/ready pipeline. Stage 1 does the range
//   check and the (row, col) transform. Stage 2 computes row*SIZE + col.
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : request handshake
//   in_x, in_y           : screen column / row (CW bits)
//   rot_cw, rot_ccw      : quarter-turn commands (both together cancel)
//   mirror_tgl           : toggle horizontal mirroring
//   orient_load/orient_in: direct load of {mirror, dir}
//   orient               : current {mirror, dir}
//   out_valid / out_ready: result handshake
//   out_index            : linear cell index (0 when out of range)
//   out_err              : request coordinate was out of range
//   out_orient           : orientation captured when the request was accepted
module maze_rotator_pipe #(
  parameter int SIZE = 22,
  localparam int CW = $clog2(SIZE),
  localparam int IW = $clog2(SIZE * SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_x,
  input  logic [CW-1:0] in_y,
  input  logic          rot_cw,
  input  logic          rot_ccw,
  input  logic          mirror_tgl,
  input  logic          orient_load,
  input  logic [2:0]    orient_in,
  output logic [2:0]    orient,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_index,
  output logic          out_err,
  output logic [2:0]    out_orient
);

  localparam logic [CW-1:0] MAX = CW'(SIZE - 1);

  logic [1:0]    dir;
  logic          mirror;

  logic          s1_valid;
  logic          s1_err;
  logic [CW-1:0] s1_row;
  logic [CW-1:0] s1_col;
  logic [2:0]    s1_orient;

  logic          s2_en;
  logic          s1_en;
  logic          in_err;
  logic [CW-1:0] rot_row;
  logic [CW-1:0] rot_col;
  logic [CW-1:0] map_col;

  // Each stage advances whenever its downstream slot is free or draining.
  // Gating with rst_n keeps in_ready low while reset is held.
  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  assign in_ready = rst_n && s1_en;
  assign orient   = {mirror, dir};

  // Orientation register. orient_load overrides everything. Opposing turn
  // commands in the same cycle cancel each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mirror <= 1'b0;
      dir    <= 2'd2;
    end else if (orient_load) begin
      mirror <= orient_in[2];
      dir    <= orient_in[1:0];
    end else begin
      if (mirror_tgl)
        mirror <= ~mirror;
      if (rot_cw && !rot_ccw)
        dir <= dir + 2'd1;
      else if (rot_ccw && !rot_cw)
        dir <= dir - 2'd1;
    end
  end

  // Rotation first, then the mirror is applied to the column.
  // When the coordinate is out of range, row/col are don't-care because
  // stage 2 forces the index to zero.
  always_comb begin
    in_err  = (32'(in_x) >= SIZE) || (32'(in_y) >= SIZE);
    rot_row = in_y;
    rot_col = in_x;
    case (dir)
      2'd0: begin rot_row = MAX - in_y; rot_col = MAX - in_x; end
      2'd1: begin rot_row = in_x;       rot_col = MAX - in_y; end
      2'd2: begin rot_row = in_y;       rot_col = in_x;       end
      2'd3: begin rot_row = MAX - in_x; rot_col = in_y;       end
      default: begin rot_row = in_y;    rot_col = in_x;       end
    endcase
    map_col = mirror ? (MAX - rot_col) : rot_col;
  end

  // Stage 1 captures the transform and the orientation seen on the accept
  // cycle. Orientation updates in that same cycle only affect later requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_err    <= 1'b0;
      s1_row    <= '0;
      s1_col    <= '0;
      s1_orient <= 3'b010;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_err    <= in_err;
        s1_row    <= rot_row;
        s1_col    <= map_col;
        s1_orient <= orient;
      end
    end
  end

  // Stage 2 does the multiply-add at 32 bits, then narrows to IW.
  // The stage holds its result while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_index  <= '0;
      out_err    <= 1'b0;
      out_orient <= 3'b010;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_index  <= s1_err ? '0 : IW'(32'(s1_row) * 32'(SIZE) + 32'(s1_col));
        out_err    <= s1_err;
        out_orient <= s1_orient;
      end
    end
  end

endmodule

// File: tb/tb_maze_rotator_pipe.sv
`timescale 1ns/1ps
// Self-checking bench for maze_rotator_pipe (SIZE = 22).
// A reference model computes the expected result and orientation for each
// accepted request and pushes it onto a queue. A monitor pops the queue and
// compares as results leave the DUT.
module tb_maze_rotator_pipe;

  localparam int SIZE = 22;
  localparam int CW = 5;
  localparam int IW = 9;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic          err;
    logic [2:0]    ori;
    logic [31:0]   accCyc;
    logic          chkLat;
  } expT;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_x;
  logic [CW-1:0] in_y;
  logic          rot_cw;
  logic          rot_ccw;
  logic          mirror_tgl;
  logic          orient_load;
  logic [2:0]    orient_in;
  logic [2:0]    orient;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_index;
  logic          out_err;
  logic [2:0]    out_orient;

  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  logic latFlag = 1'b0;
  logic [2:0] modelOrient = 3'b010;
  expT  sb[$];

  logic          prevHold = 1'b0;
  logic [IW-1:0] prevIdx;
  logic          prevErr;
  logic [2:0]    prevOri;

  maze_rotator_pipe #(.SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .rot_cw(rot_cw), .rot_ccw(rot_ccw),
    .mirror_tgl(mirror_tgl), .orient_load(orient_load), .orient_in(orient_in),
    .orient(orient), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_err(out_err), .out_orient(out_orient)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Comparison task used by every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    if (obs !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Reference model of the coordinate mapping.
  function automatic expT modelResult(input int x, input int y, input logic [2:0] o);
    expT e;
    int r, c;
    e = '0;
    e.ori = o;
    if (x >= SIZE || y >= SIZE) begin
      e.err = 1'b1;
      e.idx = '0;
    end else begin
      case (o[1:0])
        2'd0: begin r = SIZE-1-y; c = SIZE-1-x; end
        2'd1: begin r = x;        c = SIZE-1-y; end
        2'd2: begin r = y;        c = x;        end
        default: begin r = SIZE-1-x; c = y;     end
      endcase
      if (o[2]) c = SIZE-1-c;
      e.idx = IW'(r*SIZE + c);
      e.err = 1'b0;
    end
    return e;
  endfunction

  // Monitor. It samples on the falling edge, tracks the orientation model,
  // pushes an expectation on each accept, and checks each result it pops.
  always @(negedge clk) begin
    expT e;
    cyc++;
    if (!rst_n) begin
      sb.delete();
      modelOrient = 3'b010;
      prevHold = 1'b0;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst_orient", 32'(orient), 32'd2);
      checkOutput("rst_out_orient", 32'(out_orient), 32'd2);
      checkOutput("rst_out_index", 32'(out_index), 32'd0);
      checkOutput("rst_out_err", 32'(out_err), 32'd0);
    end else begin
      checkOutput("orient", 32'(orient), 32'(modelOrient));
      if (prevHold) begin
        checkOutput("hold_index", 32'(out_index), 32'(prevIdx));
        checkOutput("hold_err", 32'(out_err), 32'(prevErr));
        checkOutput("hold_orient", 32'(out_orient), 32'(prevOri));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("out_index", 32'(out_index), 32'(e.idx));
          checkOutput("out_err", 32'(out_err), 32'(e.err));
          checkOutput("out_orient", 32'(out_orient), 32'(e.ori));
          if (e.chkLat)
            checkOutput("latency", 32'(cyc) - e.accCyc, 32'd2);
        end
      end
      if (in_valid && in_ready) begin
        e = modelResult(int'(in_x), int'(in_y), modelOrient);
        e.accCyc = 32'(cyc);
        e.chkLat = latFlag;
        sb.push_back(e);
      end
      if (orient_load) begin
        modelOrient = orient_in;
      end else begin
        if (mirror_tgl) modelOrient[2] = ~modelOrient[2];
        if (rot_cw && !rot_ccw) modelOrient[1:0] = modelOrient[1:0] + 2'd1;
        if (rot_ccw && !rot_cw) modelOrient[1:0] = modelOrient[1:0] - 2'd1;
      end
      prevHold = out_valid && !out_ready;
      prevIdx  = out_index;
      prevErr  = out_err;
      prevOri  = out_orient;
    end
  end

  // Phase convention: every task starts and ends 1 ns after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one request and wait, within a bound, until it is accepted.
  task automatic applyStimulus(input int x, input int y);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_x = CW'(x);
    in_y = CW'(y);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
    end
    if (!done) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulseCmd(input logic cw, input logic ccw, input logic tgl,
                          input logic ld, input logic [2:0] oin);
    rot_cw = cw;
    rot_ccw = ccw;
    mirror_tgl = tgl;
    orient_load = ld;
    orient_in = oin;
    @(posedge clk);
    #1;
    rot_cw = 1'b0;
    rot_ccw = 1'b0;
    mirror_tgl = 1'b0;
    orient_load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_x = '0;
    in_y = '0;
    rot_cw = 1'b0;
    rot_ccw = 1'b0;
    mirror_tgl = 1'b0;
    orient_load = 1'b0;
    orient_in = 3'b000;
    out_ready = 1'b1;

    idle(3);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Identity orientation. Latency is checked on this request.
    latFlag = 1'b1;
    applyStimulus(3, 5);
    latFlag = 1'b0;
    idle(3);

    // Two clockwise turns (dir 0), then opposing turns cancel.
    pulseCmd(1, 0, 0, 0, 3'b000);
    pulseCmd(1, 0, 0, 0, 3'b000);
    applyStimulus(3, 5);
    pulseCmd(1, 1, 0, 0, 3'b000);
    @(negedge clk);
    checkOutput("cw_ccw_cancel", 32'(orient), 32'd0);
    @(posedge clk);
    #1;
    idle(3);

    // dir 3, then mirrored identity.
    pulseCmd(0, 0, 0, 1, 3'b010);
    pulseCmd(1, 0, 0, 0, 3'b000);
    applyStimulus(3, 5);
    pulseCmd(0, 0, 0, 1, 3'b010);
    pulseCmd(0, 0, 1, 0, 3'b000);
    applyStimulus(3, 5);
    idle(3);

    // Range boundaries at the identity orientation.
    pulseCmd(0, 0, 0, 1, 3'b010);
    applyStimulus(22, 0);
    applyStimulus(0, 0);
    applyStimulus(0, 22);
    applyStimulus(21, 21);
    applyStimulus(31, 31);
    idle(4);

    // Backpressure: four requests queue up against a stalled consumer.
    out_ready = 1'b0;
    fork
      begin
        applyStimulus(1, 2);
        applyStimulus(4, 7);
        applyStimulus(10, 0);
        applyStimulus(21, 21);
      end
      begin
        idle(6);
        @(negedge clk);
        checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          checkOutput("burst_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
      end
    join
    idle(4);

    // Reset with two requests in flight; neither one may appear later.
    pulseCmd(0, 0, 0, 1, 3'b101);
    applyStimulus(5, 5);
    applyStimulus(6, 6);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("kill_out_valid", 32'(out_valid), 32'd0);
    checkOutput("kill_orient", 32'(orient), 32'd2);
    @(posedge clk);
    #1;
    idle(1);
    rst_n = 1'b1;
    idle(6);

    // Random mix of requests, orientation commands and backpressure.
    for (int i = 0; i < 300; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_x        = CW'($urandom_range(0, 23));
      in_y        = CW'($urandom_range(0, 23));
      rot_cw      = ($urandom_range(0, 3) == 0);
      rot_ccw     = ($urandom_range(0, 3) == 0);
      mirror_tgl  = ($urandom_range(0, 4) == 0);
      orient_load = ($urandom_range(0, 9) == 0);
      orient_in   = 3'($urandom_range(0, 7));
      out_ready   = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rot_cw = 1'b0;
    rot_ccw = 1'b0;
    mirror_tgl = 1'b0;
    orient_load = 1'b0;
    out_ready = 1'b1;
    idle(6);
    checkOutput("drain_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
